// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: direction counter encodings, resolver codes, default widths.
// Pure constants; no latency or backpressure.
package branch_pkg;
   localparam int DBITS_DEF      = 32;
   localparam int INDEX_BITS_DEF = 4;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic RES_MISPRED = 1'b0;
   localparam logic RES_CORRECT = 1'b1;

   localparam logic [1:0] BR_COND = 2'd0;
   localparam logic [1:0] BR_JAL  = 2'd1;
   localparam logic [1:0] BR_JALR = 2'd2;
endpackage

// File: rtl/branch_predictor_sat_counter_2b.sv
// Two-bit saturating direction counter next-state; purely combinational, 0 cycles.
// No flow control: evaluated every cycle, the caller decides whether to commit.
module sat_counter_2b
   import branch_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != ST) ctr_next = ctr + 2'b01;
      end else begin
         if (ctr != SNT) ctr_next = ctr - 2'b01;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Direction counters + direct-mapped BTB; lookup 0 cycles, update visible next cycle.
// No backpressure: one resolved branch accepted per cycle, lookups never stall.
module branch_predictor
   import branch_pkg::*;
#(
   parameter int DBITS      = DBITS_DEF,
   parameter int INDEX_BITS = INDEX_BITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] IF_PC,
   output logic             prediction,
   output logic [DBITS-1:0] predPC,
   input  logic             update,
   input  logic [DBITS-1:0] updPC,
   input  logic             updTaken,
   input  logic [DBITS-1:0] updTarget,
   input  logic             updCorrect,
   output logic [DBITS-1:0] branchCount,
   output logic [DBITS-1:0] mispredCount
);
   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = DBITS - INDEX_BITS - 2;

   logic                valid_q [ENTRIES];
   logic [TAG_BITS-1:0] tag_q   [ENTRIES];
   logic [DBITS-1:0]    tgt_q   [ENTRIES];
   logic [1:0]          ctr_q   [ENTRIES];

   logic [DBITS-1:0]    branch_cnt_q;
   logic [DBITS-1:0]    mispred_cnt_q;

   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0]   if_tag;
   logic                  if_hit;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_hit;
   logic [1:0]            upd_ctr_next;
   logic                  unused_pc_lsbs;

   assign unused_pc_lsbs = ^{IF_PC[1:0], updPC[1:0]};

   assign if_idx = IF_PC[INDEX_BITS+1:2];
   assign if_tag = IF_PC[DBITS-1:INDEX_BITS+2];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   // Reads the registered table only, so a same-cycle update is not seen here.
   assign prediction = if_hit && ctr_q[if_idx][1];
   assign predPC     = prediction ? tgt_q[if_idx] : IF_PC + DBITS'(4);

   assign upd_idx = updPC[INDEX_BITS+1:2];
   assign upd_tag = updPC[DBITS-1:INDEX_BITS+2];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   sat_counter_2b u_sat (
      .ctr      (ctr_q[upd_idx]),
      .taken    (updTaken),
      .ctr_next (upd_ctr_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= WNT;
         end
      end else if (update) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= upd_ctr_next;
            if (updTaken) tgt_q[upd_idx] <= updTarget;
         end else begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= updTarget;
            ctr_q[upd_idx]   <= updTaken ? WT : WNT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (update) begin
         if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + DBITS'(1);
         if ((updCorrect == RES_MISPRED) && (mispred_cnt_q != '1))
            mispred_cnt_q <= mispred_cnt_q + DBITS'(1);
      end
   end

   assign branchCount  = branch_cnt_q;
   assign mispredCount = mispred_cnt_q;
endmodule
